// File: rtl/dccm_port_arbiter.sv
// Arbitrates the DCCM read and write ports between the LSU and a DMA/debug requester.
// The LSU has priority and the DMA is starvation-protected. Read returns are routed back to whoever issued the read.
module dccm_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int RD_LAT     = 1,
  parameter int MAX_STARVE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lsu_raddr,
  input  logic            lsu_rvalid_in,
  output logic [XLEN-1:0] lsu_rdata,
  output logic            lsu_rvalid_out,
  input  logic [XLEN-1:0] lsu_waddr,
  input  logic            lsu_wen,
  input  logic [XLEN-1:0] lsu_wdata,
  output logic            lsu_stall,
  input  logic            dma_req,
  input  logic            dma_we,
  input  logic [XLEN-1:0] dma_addr,
  input  logic [XLEN-1:0] dma_wdata,
  output logic            dma_gnt,
  output logic [XLEN-1:0] dma_rdata,
  output logic            dma_rvalid,
  output logic [XLEN-1:0] dccm_raddr,
  output logic            dccm_rvalid_in,
  input  logic [XLEN-1:0] dccm_rdata,
  input  logic            dccm_rvalid_out,
  output logic [XLEN-1:0] dccm_waddr,
  output logic            dccm_wen,
  output logic [XLEN-1:0] dccm_wdata,
  output logic            rd_err
);

  localparam int SW = $clog2(MAX_STARVE + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);

  logic [SW-1:0]     starve_q, starve_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [RD_LAT-1:0] own_q, own_d;
  logic              rd_err_q, rd_err_d;

  logic conflict, dma_wins, dma_rd_win, dma_wr_win;
  logic ent_vld, ent_own;

  always_comb begin
    conflict   = dma_req && (dma_we ? lsu_wen : lsu_rvalid_in);
    dma_wins   = !rst && dma_req && (!conflict || starve_q == STARVE_MAX);
    dma_rd_win = dma_wins && !dma_we;
    dma_wr_win = dma_wins && dma_we;

    dma_gnt   = dma_wins;
    lsu_stall = dma_wins && conflict;

    // Each port is muxed on its own, so a DMA write never blocks an LSU read and vice versa.
    dccm_raddr     = dma_rd_win ? dma_addr : lsu_raddr;
    dccm_rvalid_in = !rst && (dma_rd_win || lsu_rvalid_in);
    dccm_waddr     = dma_wr_win ? dma_addr  : lsu_waddr;
    dccm_wdata     = dma_wr_win ? dma_wdata : lsu_wdata;
    dccm_wen       = !rst && (dma_wr_win || lsu_wen);

    starve_d = starve_q;
    if (!dma_req || dma_wins)
      starve_d = '0;
    else if (conflict && starve_q != STARVE_MAX)
      starve_d = starve_q + 1'b1;

    vld_d[0] = dccm_rvalid_in;
    own_d[0] = dma_rd_win;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      own_d[i] = own_q[i-1];
    end

    ent_vld = vld_q[RD_LAT-1];
    ent_own = own_q[RD_LAT-1];

    // A return with no tracked read is dropped and flagged; a tracked read without a return is ignored.
    lsu_rvalid_out = !rst && dccm_rvalid_out && ent_vld && !ent_own;
    dma_rvalid     = !rst && dccm_rvalid_out && ent_vld && ent_own;
    lsu_rdata      = dccm_rdata;
    dma_rdata      = dccm_rdata;

    rd_err_d = rd_err_q || (dccm_rvalid_out && !ent_vld);
    rd_err   = rd_err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
      vld_q    <= '0;
      own_q    <= '0;
      rd_err_q <= 1'b0;
    end else begin
      starve_q <= starve_d;
      vld_q    <= vld_d;
      own_q    <= own_d;
      rd_err_q <= rd_err_d;
    end
  end

endmodule
